// File: rtl/fft_frame_ctrl.sv
// Frame controller for an N = 2**POW point FFT core: load, staged compute, unload.
// Define FFT_CTRL_BITREV_EN for natural-order output (bit-reversed read address).
module fft_frame_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int POW        = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sink_valid,
    input  logic           sink_sop,
    output logic           sink_ready,
    output logic           wr_en,
    output logic [POW-1:0] wr_addr,
    output logic [POW-1:0] stage_en,
    output logic           source_valid,
    input  logic           source_ready,
    output logic           source_sop,
    output logic           source_eop,
    output logic [POW-1:0] rd_addr,
    output logic           busy
);

    if (POW < 1 || POW > 10 || DATA_WIDTH < 2) begin : g_bad_param
        $error("fft_frame_ctrl: POW must be 1..10 and DATA_WIDTH at least 2");
    end

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    localparam logic [POW-1:0] LAST_IDX   = '1;
    localparam logic [3:0]     LAST_STAGE = 4'(POW - 1);

    state_t         state_reg, state_next;
    logic [POW-1:0] load_cnt_reg, load_cnt_next;
    logic [3:0]     stage_cnt_reg, stage_cnt_next;
    logic [POW-1:0] idx_reg, idx_next;
    logic [POW-1:0] idx_mapped;
    logic [POW-1:0] stage_hot;

    logic in_load, in_compute, in_unload;
    logic accept, beat;

    assign in_load    = (state_reg == ST_LOAD);
    assign in_compute = (state_reg == ST_COMPUTE);
    assign in_unload  = (state_reg == ST_UNLOAD);
    assign accept     = in_load && sink_valid;
    assign beat       = in_unload && source_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            load_cnt_reg  <= '0;
            stage_cnt_reg <= '0;
            idx_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            load_cnt_reg  <= load_cnt_next;
            stage_cnt_reg <= stage_cnt_next;
            idx_reg       <= idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_cnt_next  = load_cnt_reg;
        stage_cnt_next = stage_cnt_reg;
        idx_next       = idx_reg;
        case (state_reg)
            ST_LOAD: begin
                if (accept) begin
                    // A start-of-packet restarts the frame: its sample lands at 0.
                    if (sink_sop) begin
                        load_cnt_next = POW'(1);
                    end else if (load_cnt_reg == LAST_IDX) begin
                        load_cnt_next  = '0;
                        stage_cnt_next = '0;
                        state_next     = ST_COMPUTE;
                    end else begin
                        load_cnt_next = load_cnt_reg + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (stage_cnt_reg == LAST_STAGE) begin
                    stage_cnt_next = '0;
                    idx_next       = '0;
                    state_next     = ST_UNLOAD;
                end else begin
                    stage_cnt_next = stage_cnt_reg + 4'd1;
                end
            end
            ST_UNLOAD: begin
                if (beat) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = ST_LOAD;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next     = ST_LOAD;
                load_cnt_next  = '0;
                stage_cnt_next = '0;
                idx_next       = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < POW; gi++) begin : g_stage
            assign stage_hot[gi] = in_compute && (stage_cnt_reg == 4'(gi));
        end
`ifdef FFT_CTRL_BITREV_EN
        for (gi = 0; gi < POW; gi++) begin : g_bitrev
            assign idx_mapped[gi] = idx_reg[POW-1-gi];
        end
`else
        assign idx_mapped = idx_reg;
`endif
    endgenerate

    // Outputs are forced low combinationally while rst is held, not just after the edge.
    always_comb begin
        sink_ready   = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        stage_en     = '0;
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        rd_addr      = '0;
        busy         = 1'b0;
        if (!rst) begin
            sink_ready   = in_load;
            wr_en        = accept;
            wr_addr      = (accept && sink_sop) ? '0 : load_cnt_reg;
            stage_en     = stage_hot;
            source_valid = in_unload;
            source_sop   = in_unload && (idx_reg == '0);
            source_eop   = in_unload && (idx_reg == LAST_IDX);
            rd_addr      = in_unload ? idx_mapped : '0;
            busy         = in_compute || in_unload;
        end
    end

endmodule
